// File: rtl/fetch_redirect_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_redirect_unit_pkg;
  typedef enum logic [1:0] {BOOT, FETCH, DRAIN, HOLD} state_t;

  localparam int                 INSTR_W = 32;
  localparam logic [31:0]        PC_INC  = 32'd4;
  localparam logic [INSTR_W-1:0] NOP     = '0;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_redirect_unit_if_id_reg.sv
// IF/ID pipeline register. Priority: clear > load > hold; with none asserted
// the slot empties so ID never sees the same instruction twice.
module fetch_redirect_unit_if_id_reg
  import fetch_redirect_unit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_load,
  input  logic               i_hold,
  input  logic               i_clear,
  input  logic [INSTR_W-1:0] i_instr,
  input  logic [31:0]        i_pc4,
  output logic [INSTR_W-1:0] o_instr,
  output logic [31:0]        o_pc4,
  output logic               o_valid
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_instr <= NOP;
      o_pc4   <= '0;
      o_valid <= 1'b0;
    end else if (i_clear) begin
      o_instr <= NOP;
      o_valid <= 1'b0;
    end else if (i_load) begin
      o_instr <= i_instr;
      o_pc4   <= i_pc4;
      o_valid <= 1'b1;
    end else if (!i_hold) begin
      o_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/fetch_redirect_unit.sv
// Fetch PC owner: imem request FSM, branch/jump redirect, stall hold buffer,
// and discard of responses made stale by a redirect.
module fetch_redirect_unit
  import fetch_redirect_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               PCSrc,
  input  logic [31:0]        branch_target,
  input  logic               Jump,
  input  logic [31:0]        jump_target,
  input  logic               stall,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic               if_id_flush
);
  state_t             r_state, w_state_nxt;
  logic [31:0]        r_fetch_pc, w_fetch_pc_nxt;
  logic [31:0]        r_pend_pc, w_pend_pc_nxt;
  logic [INSTR_W-1:0] r_hold_instr;
  logic [31:0]        r_hold_pc4;
  logic               w_hold_ld, w_load;
  logic [INSTR_W-1:0] w_ld_instr;
  logic [31:0]        w_ld_pc4;

  // A redirect seen during a stall is ignored; ID re-presents it later.
  logic        w_redir;
  logic [31:0] w_target, w_pc4;
  assign w_redir  = (Jump | PCSrc) & ~stall;
  assign w_target = word_align(Jump ? jump_target : branch_target);
  assign w_pc4    = r_fetch_pc + PC_INC;

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_pend_pc_nxt  = r_pend_pc;
    w_hold_ld      = 1'b0;
    w_load         = 1'b0;
    w_ld_instr     = imem_rdata;
    w_ld_pc4       = w_pc4;
    case (r_state)
      BOOT: begin
        w_state_nxt = FETCH;
        if (w_redir) w_fetch_pc_nxt = w_target;
      end
      FETCH: begin
        if (imem_ready) begin
          if (w_redir) begin
            w_fetch_pc_nxt = w_target;
          end else if (stall) begin
            w_hold_ld   = 1'b1;
            w_state_nxt = HOLD;
          end else begin
            w_load         = 1'b1;
            w_fetch_pc_nxt = w_pc4;
          end
        end else if (w_redir) begin
          // Address must stay put until the outstanding response returns.
          w_pend_pc_nxt = w_target;
          w_state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        if (w_redir) w_pend_pc_nxt = w_target;
        if (imem_ready) begin
          w_fetch_pc_nxt = w_redir ? w_target : r_pend_pc;
          w_state_nxt    = FETCH;
        end
      end
      HOLD: begin
        if (w_redir) begin
          w_fetch_pc_nxt = w_target;
          w_state_nxt    = FETCH;
        end else if (!stall) begin
          w_load         = 1'b1;
          w_ld_instr     = r_hold_instr;
          w_ld_pc4       = r_hold_pc4;
          w_fetch_pc_nxt = w_pc4;
          w_state_nxt    = FETCH;
        end
      end
      default: w_state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= BOOT;
      r_fetch_pc   <= RESET_PC;
      r_pend_pc    <= RESET_PC;
      r_hold_instr <= NOP;
      r_hold_pc4   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_pend_pc  <= w_pend_pc_nxt;
      if (w_hold_ld) begin
        r_hold_instr <= imem_rdata;
        r_hold_pc4   <= w_pc4;
      end
    end
  end

  assign imem_req    = (r_state == FETCH) || (r_state == DRAIN);
  assign imem_addr   = r_fetch_pc;
  assign if_id_flush = w_redir;

  fetch_redirect_unit_if_id_reg u_if_id (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_load),
    .i_hold  (stall),
    .i_clear (w_redir),
    .i_instr (w_ld_instr),
    .i_pc4   (w_ld_pc4),
    .o_instr (if_id_instr),
    .o_pc4   (if_id_pc4),
    .o_valid (if_id_valid)
  );
endmodule

// File: tb/tb_fetch_redirect_unit.sv
// Directed bench: stimulus pushes expected IF/ID entries, a monitor pops and
// compares each newly loaded IF/ID entry.
module tb_fetch_redirect_unit;
  localparam logic [31:0] K     = 32'hC0DE_0000;
  localparam logic [31:0] FIXED = 32'h8C01_0004;

  logic        clk = 1'b0;
  logic        rst_n, PCSrc, Jump, stall, imem_ready, use_fixed;
  logic [31:0] branch_target, jump_target;
  logic        imem_req, if_id_valid, if_id_flush;
  logic [31:0] imem_addr, imem_rdata, if_id_instr, if_id_pc4;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb[$];

  always #5 clk = ~clk;

  assign imem_rdata = use_fixed ? FIXED : (imem_addr ^ K);

  fetch_redirect_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .PCSrc(PCSrc), .branch_target(branch_target),
    .Jump(Jump), .jump_target(jump_target), .stall(stall),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rdata(imem_rdata), .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .if_id_flush(if_id_flush)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push_raw(input logic [31:0] instr, input logic [31:0] pc4);
    sb.push_back({instr, pc4});
  endtask

  task automatic push_addr(input logic [31:0] a);
    logic [31:0] p4;
    p4 = a + 32'd4;
    sb.push_back({a ^ K, p4});
  endtask

  // A freshly loaded IF/ID entry is one that is valid after an edge where stall was low.
  always @(posedge clk) begin
    logic s_stall, s_rst;
    logic [63:0] exp;
    s_stall = stall;
    s_rst   = rst_n;
    #1;
    if (s_rst && rst_n && if_id_valid && !s_stall) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", {if_id_instr, if_id_pc4}, 64'h0);
      end else begin
        exp = sb.pop_front();
        chk("ifid_entry", {if_id_instr, if_id_pc4}, exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; Jump = 1'b0; PCSrc = 1'b0; stall = 1'b0;
    branch_target = '0; jump_target = '0; use_fixed = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req",   imem_req,    0);
    chk("rst_addr",  imem_addr,   0);
    chk("rst_instr", if_id_instr, 0);
    chk("rst_pc4",   if_id_pc4,   0);
    chk("rst_valid", if_id_valid, 0);
    chk("rst_flush", if_id_flush, 0);
    rst_n = 1'b1;

    // Sequential fetch from RESET_PC with zero-wait memory.
    @(negedge clk);
    chk("boot_req", imem_req, 1); chk("boot_addr", imem_addr, 0); chk("boot_valid", if_id_valid, 0);
    push_addr(32'h0);
    @(negedge clk); chk("seq_addr4", imem_addr, 32'h4); push_addr(32'h4);
    @(negedge clk); chk("seq_addr8", imem_addr, 32'h8); push_addr(32'h8);

    // Jump and branch together: jump wins, wrong-path 0xC dropped.
    @(negedge clk); chk("seq_addr12", imem_addr, 32'hC);
    Jump = 1'b1; jump_target = 32'h40; PCSrc = 1'b1; branch_target = 32'h80;
    #1 chk("jmp_flush", if_id_flush, 1);
    @(negedge clk); Jump = 1'b0; PCSrc = 1'b0;
    #1 chk("jmp_flush_off", if_id_flush, 0);
    chk("jmp_addr", imem_addr, 32'h40); chk("jmp_bubble", if_id_valid, 0);
    push_addr(32'h40);

    // Redirect to 0x20, then redirect to 0x100 while 0x20 waits 3 cycles.
    @(negedge clk); chk("addr44", imem_addr, 32'h44); Jump = 1'b1; jump_target = 32'h20;
    @(negedge clk); Jump = 1'b0; imem_ready = 1'b0;
    chk("drn_addr0", imem_addr, 32'h20); chk("drn_req0", imem_req, 1);
    PCSrc = 1'b1; branch_target = 32'h100;
    #1 chk("drn_flush", if_id_flush, 1);
    @(negedge clk); PCSrc = 1'b0; chk("drn_addr1", imem_addr, 32'h20); chk("drn_req1", imem_req, 1);
    @(negedge clk); chk("drn_addr2", imem_addr, 32'h20);
    @(negedge clk); chk("drn_addr3", imem_addr, 32'h20); imem_ready = 1'b1;
    @(negedge clk); chk("drn_target", imem_addr, 32'h100); push_addr(32'h100);

    // Stall coincident with ready: response parked, IF/ID frozen.
    @(negedge clk); chk("addr104", imem_addr, 32'h104); stall = 1'b1; use_fixed = 1'b1;
    @(negedge clk); chk("hold_req", imem_req, 0);
    chk("hold_instr", if_id_instr, 32'h100 ^ K); chk("hold_pc4", if_id_pc4, 32'h104);
    stall = 1'b0; use_fixed = 1'b0; push_raw(FIXED, 32'h108);
    @(negedge clk); chk("hold_next", imem_addr, 32'h108); chk("hold_out", if_id_instr, FIXED);
    push_addr(32'h108);

    // Stall together with a branch: redirect ignored, IF/ID held.
    @(negedge clk); stall = 1'b1; PCSrc = 1'b1; branch_target = 32'h200; imem_ready = 1'b0;
    #1 chk("stl_noflush", if_id_flush, 0);
    @(negedge clk); chk("stl_valid", if_id_valid, 1); chk("stl_instr", if_id_instr, 32'h108 ^ K);
    chk("stl_addr", imem_addr, 32'h10C);
    PCSrc = 1'b0; stall = 1'b0; imem_ready = 1'b1; push_addr(32'h10C);

    // Jump to top of memory (low bits forced to 0) and wrap.
    @(negedge clk); Jump = 1'b1; jump_target = 32'hFFFF_FFFF;
    #1 chk("wrap_flush", if_id_flush, 1);
    @(negedge clk); Jump = 1'b0; chk("wrap_top", imem_addr, 32'hFFFF_FFFC); push_addr(32'hFFFF_FFFC);
    @(negedge clk); chk("wrap_addr", imem_addr, 32'h0); chk("wrap_pc4", if_id_pc4, 32'h0);
    push_addr(32'h0);
    @(negedge clk); imem_ready = 1'b0;

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_redirect_unit.md
# fetch_redirect_unit

Instruction-fetch front end: the consumer of the ID-stage branch/jump decision. Owns the fetch PC, drives the instruction-memory request handshake, and holds the IF/ID pipeline register. It applies redirects (PCSrc/Jump), flushes the wrong-path instruction, honours hazard stalls, and discards in-flight responses made stale by a redirect.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PCSrc  in  1  ID-stage conditional branch taken (beq/bne resolved)
- branch_target  in  32  branch destination, valid when PCSrc=1
- Jump  in  1  ID-stage unconditional jump
- jump_target  in  32  jump destination, valid when Jump=1
- stall  in  1  hazard unit freeze of IF and IF/ID
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, stable while imem_req=1 and imem_ready=0
- imem_ready  in  1  response strobe; imem_rdata valid in the same cycle
- imem_rdata  in  32  fetched instruction
- if_id_instr  out  32  IF/ID instruction
- if_id_pc4  out  32  IF/ID PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction
- if_id_flush  out  1  combinational pulse: redirect accepted this cycle

## Operation
- Redirect request: Jump or PCSrc; Jump has priority (target = jump_target). Target bits [1:0] forced to 0.
- Redirect accepted only when stall=0. When stall=1, the redirect is ignored; ID re-presents it.
- Accepted redirect: if_id_valid <= 0, if_id_flush=1 that cycle, fetch restarts at the target.
- Sequential fetch: fetch_pc <= fetch_pc + 4, mod 2^32 (FFFF_FFFC wraps to 0000_0000).
- States:
  - BOOT: imem_req=0; next cycle -> FETCH.
  - FETCH: imem_req=1, imem_addr=fetch_pc.
    - ready & no redirect & !stall: IF/ID <= {rdata, fetch_pc+4}, valid=1, fetch_pc+=4.
    - ready & stall: rdata/pc4 -> hold buffer -> HOLD. IF/ID unchanged.
    - ready & redirect: drop rdata, fetch_pc <= target, stay FETCH.
    - !ready & redirect: pend_pc <= target -> DRAIN.
    - !ready & stall: wait; IF/ID unchanged.
  - DRAIN: imem_req=1, imem_addr unchanged (stale). Any new redirect overwrites pend_pc. On ready: drop rdata, fetch_pc <= pend_pc -> FETCH.
  - HOLD: imem_req=0.
    - stall=0 & no redirect: IF/ID <= hold buffer, fetch_pc+=4 -> FETCH.
    - redirect: discard hold, fetch_pc <= target -> FETCH.
- stall=1 with no redirect: IF/ID holds all fields, including if_id_valid.
- Reset mid-transaction: all state cleared; any response arriving before the first post-BOOT request is ignored.

## Timing
- Reset values: imem_req=0, imem_addr=RESET_PC, if_id_instr=0, if_id_pc4=0, if_id_valid=0, if_id_flush=0, state=BOOT.
- First imem_req=1 one cycle after rst_n deasserts.
- Zero-wait memory (imem_ready tied high): one instruction per cycle, throughput 1.
- Fetch-to-IF/ID latency: 1 clock edge after the ready cycle.
- Redirect penalty with zero-wait memory: 1 bubble. First target instruction reaches IF/ID 2 edges after the accepted redirect cycle.
- Redirect penalty in DRAIN: remaining wait cycles plus 1 extra request.
- Handshake: imem_addr must not change while imem_req=1 and imem_ready=0. imem_req may drop only after ready, or on BOOT/HOLD entry.
- Registered outputs: imem_addr, if_id_*. Combinational outputs: imem_req (from state) and if_id_flush.

## Structure
- Shared package holds:
  - State enum: BOOT, FETCH, DRAIN, HOLD.
  - Constants: INSTR_W=32, PC_INC=4, NOP=32'h0000_0000.
- One natural sub-module: if_id_reg, the IF/ID register with load, hold and clear controls, reused by the hazard-unit bench.
- The rest is the FSM plus the fetch_pc, pend_pc and hold-buffer datapath in the top.

## Test plan
- Reset release, ready=1, RESET_PC=0: imem_addr sequence 0,4,8 starting one cycle after BOOT; if_id_pc4 = 4,8,12; if_id_valid rises on edge 2.
- Jump=1, jump_target=0x40, in the same cycle as PCSrc=1, branch_target=0x80: if_id_flush=1; next imem_addr=0x40; if_id_valid=0 for 1 cycle.
- Redirect to 0x100 while a request to 0x20 waits (ready low 3 cycles): addr stays 0x20 until ready; 0x20 data is discarded; next request is 0x100.
- stall=1 coincident with ready, rdata=0x8C01_0004: IF/ID unchanged, imem_req=0. After stall drops, if_id_instr=0x8C01_0004 and the next fetch is addr+4.
- stall=1 together with PCSrc=1: redirect ignored, if_id_flush=0, IF/ID held.
- fetch_pc=0xFFFF_FFFC accepted: next imem_addr=0x0000_0000; if_id_pc4=0x0000_0000.
